fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined core.
- Owns the program counter and drives the fetch address into the combinational-read instruction memory.
- Registers the returned instruction word, together with its PC and PC+4, into the IF/ID pipeline register consumed by decode.
- Handles stall, flush, branch redirect and out-of-range fetch detection. Also provides a retired-fetch counter.

---
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and fills the
// IF/ID pipeline register. It also handles stall, flush, redirect and out-of-range fetches.
module fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned IMEM_ADDR_BITS = 23,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        branch_taken_e,
    input  logic [31:0] branch_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        fault_d,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] pc_plus4_d_q, pc_plus4_d_d;
    logic        valid_d_q, valid_d_d;
    logic        fault_d_q, fault_d_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_f_plus4;
    logic        fetch_fault;

    assign pc_f_plus4  = pc_f_q + 32'd4;
    // Any PC bit at or above the decoded window marks the fetch as out of range.
    assign fetch_fault = (pc_f_q >> IMEM_ADDR_BITS) != 32'd0;

    always_comb begin
        pc_f_d = pc_f_q;
        if (branch_taken_e) begin
            pc_f_d = {branch_target_e[31:2], 2'b00};
        end else if (!stall_f) begin
            pc_f_d = pc_f_plus4;
        end
    end

    always_comb begin
        instr_d_d     = instr_d_q;
        pc_d_d        = pc_d_q;
        pc_plus4_d_d  = pc_plus4_d_q;
        valid_d_d     = valid_d_q;
        fault_d_d     = fault_d_q;
        fetch_count_d = fetch_count_q;
        // A taken branch squashes the wrong-path instruction currently being fetched.
        if (flush_d || branch_taken_e) begin
            instr_d_d    = NOP_INSTR;
            pc_d_d       = 32'd0;
            pc_plus4_d_d = 32'd0;
            valid_d_d    = 1'b0;
            fault_d_d    = 1'b0;
        end else if (!stall_d) begin
            instr_d_d    = fetch_fault ? NOP_INSTR : imem_rdata;
            pc_d_d       = pc_f_q;
            pc_plus4_d_d = pc_f_plus4;
            valid_d_d    = 1'b1;
            fault_d_d    = fetch_fault;
            if (!fetch_fault) begin
                fetch_count_d = fetch_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q        <= RESET_PC;
            instr_d_q     <= NOP_INSTR;
            pc_d_q        <= 32'd0;
            pc_plus4_d_q  <= 32'd0;
            valid_d_q     <= 1'b0;
            fault_d_q     <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_f_q        <= pc_f_d;
            instr_d_q     <= instr_d_d;
            pc_d_q        <= pc_d_d;
            pc_plus4_d_q  <= pc_plus4_d_d;
            valid_d_q     <= valid_d_d;
            fault_d_q     <= fault_d_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_f_q;
    assign pc_f        = pc_f_q;
    assign instr_d     = instr_d_q;
    assign pc_d        = pc_d_q;
    assign pc_plus4_d  = pc_plus4_d_q;
    assign valid_d     = valid_d_q;
    assign fault_d     = fault_d_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns the word equal to its address.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall_f, stall_d, flush_d, branch_taken_e;
    logic [31:0] branch_target_e, imem_addr, imem_rdata, pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, fault_d;
    logic [31:0] fetch_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr;

    fetch_stage #(
        .RESET_PC      (32'h0000_0000),
        .IMEM_ADDR_BITS(23),
        .NOP_INSTR     (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .branch_taken_e (branch_taken_e),
        .branch_target_e(branch_target_e),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc_f           (pc_f),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pc_plus4_d     (pc_plus4_d),
        .valid_d        (valid_d),
        .fault_d        (fault_d),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full IF/ID + PC snapshot check.
    task automatic chk_all(input string tag, input logic [31:0] e_pcf, input logic [31:0] e_instr,
                           input logic [31:0] e_pcd, input logic [31:0] e_pc4, input logic e_valid,
                           input logic e_fault, input logic [31:0] e_cnt);
        chk({tag, ".pc_f"}, pc_f, e_pcf);
        chk({tag, ".imem_addr"}, imem_addr, e_pcf);
        chk({tag, ".instr_d"}, instr_d, e_instr);
        chk({tag, ".pc_d"}, pc_d, e_pcd);
        chk({tag, ".pc_plus4_d"}, pc_plus4_d, e_pc4);
        chk({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, e_valid});
        chk({tag, ".fault_d"}, {31'd0, fault_d}, {31'd0, e_fault});
        chk({tag, ".fetch_count"}, fetch_count, e_cnt);
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        branch_taken_e = 1'b0; branch_target_e = 32'd0;
        #2;
        tick(); tick();
        chk_all("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        reset = 1'b0;
        tick(); chk_all("seq0", 32'h4, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1);
        tick(); chk_all("seq1", 32'h8, 32'h4, 32'h4, 32'h8, 1'b1, 1'b0, 32'd2);
        tick(); chk_all("seq2", 32'hC, 32'h8, 32'h8, 32'hC, 1'b1, 1'b0, 32'd3);
        tick(); chk_all("seq3", 32'h10, 32'hC, 32'hC, 32'h10, 1'b1, 1'b0, 32'd4);

        stall_f = 1'b1; stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("stall", 32'h10, 32'hC, 32'hC, 32'h10, 1'b1, 1'b0, 32'd4);
        end
        stall_f = 1'b0; stall_d = 1'b0;
        tick(); chk_all("resume", 32'h14, 32'h10, 32'h10, 32'h14, 1'b1, 1'b0, 32'd5);

        // Redirect beats stall_f, low target bits dropped, wrong-path fetch squashed.
        stall_f = 1'b1; branch_taken_e = 1'b1; branch_target_e = 32'h103;
        tick(); chk_all("redir", 32'h100, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);
        stall_f = 1'b0; branch_taken_e = 1'b0;
        tick(); chk_all("redir_cap", 32'h104, 32'h100, 32'h100, 32'h104, 1'b1, 1'b0, 32'd6);

        flush_d = 1'b1; stall_d = 1'b1;
        tick(); chk_all("flush", 32'h108, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'd6);
        flush_d = 1'b0; stall_d = 1'b0;
        tick(); chk_all("post_flush", 32'h10C, 32'h108, 32'h108, 32'h10C, 1'b1, 1'b0, 32'd7);

        branch_taken_e = 1'b1; branch_target_e = 32'h0080_0000;
        tick(); chk_all("oor_redir", 32'h0080_0000, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'd7);
        branch_taken_e = 1'b0;
        tick(); chk_all("oor_cap", 32'h0080_0004, NOP, 32'h0080_0000, 32'h0080_0004, 1'b1, 1'b1, 32'd7);

        // Just below the window boundary is still in range.
        branch_taken_e = 1'b1; branch_target_e = 32'h007F_FFFC;
        tick(); branch_taken_e = 1'b0;
        tick(); chk_all("edge_cap", 32'h0080_0000, 32'h007F_FFFC, 32'h007F_FFFC, 32'h0080_0000,
                        1'b1, 1'b0, 32'd8);

        branch_taken_e = 1'b1; branch_target_e = 32'hFFFF_FFFC;
        tick(); chk("wrap_redir.pc_f", pc_f, 32'hFFFF_FFFC);
        branch_taken_e = 1'b0;
        tick(); chk_all("wrap_cap", 32'h0, NOP, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 32'd8);
        tick(); chk_all("wrap_next", 32'h4, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 32'd9);

        // stall_f alone re-captures the same PC and counts each capture.
        stall_f = 1'b1;
        tick(); chk_all("refetch0", 32'h4, 32'h4, 32'h4, 32'h8, 1'b1, 1'b0, 32'd10);
        tick(); chk_all("refetch1", 32'h4, 32'h4, 32'h4, 32'h8, 1'b1, 1'b0, 32'd11);
        stall_f = 1'b0;

        reset = 1'b1; branch_taken_e = 1'b1; branch_target_e = 32'h200; stall_d = 1'b1;
        tick(); chk_all("reset_redir", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0; branch_taken_e = 1'b0; stall_d = 1'b0;
        tick(); chk_all("after_reset", 32'h4, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
